// File: rtl/nn_pkg.sv
// nn_pkg: encodings shared by the layer scheduler and the dense-layer engine.
// Activation type plus engine source/destination buffer selects.
package nn_pkg;

  typedef enum logic {
    RELU    = 1'b0,
    SIGMOID = 1'b1
  } activation_t;

  typedef enum logic [1:0] {
    SRC_EXT   = 2'd0,
    SRC_BUF_A = 2'd1,
    SRC_BUF_B = 2'd2
  } src_sel_t;

  typedef enum logic [1:0] {
    DST_BUF_A = 2'd1,
    DST_BUF_B = 2'd2,
    DST_OUT   = 2'd3
  } dst_sel_t;

  // Layers ping-pong between the two buffers; first reads EXT, last writes OUT.
  function automatic src_sel_t src_for(logic first, logic odd);
    if (first) return SRC_EXT;
    if (odd)   return SRC_BUF_A;
    return SRC_BUF_B;
  endfunction

  function automatic dst_sel_t dst_for(logic last, logic odd);
    if (last) return DST_OUT;
    if (odd)  return DST_BUF_B;
    return DST_BUF_A;
  endfunction

endpackage

// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences NUM_LAYERS passes through one shared dense-layer
// engine, steering buffers per layer, with a per-layer timeout and abort.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LAYERS = 3,
  parameter logic [NUM_LAYERS-1:0] ACTIVATIONS = {SIGMOID, RELU, RELU},
  parameter int TIMEOUT = 1024,
  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic          abort,
  output logic          layer_start,
  output logic [IW-1:0] layer_index,
  output logic          activation,
  output logic [1:0]    src_sel,
  output logic [1:0]    dst_sel,
  input  logic          layer_done,
  output logic          outputs_valid,
  input  logic          outputs_ack,
  output logic          busy,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LAYERS - 1);
  localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT - 1);

  if (DATA_WIDTH < 1) begin : g_bad_data_width
  end

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    src_q, src_d;
  logic [1:0]    dst_q, dst_d;
  logic [IW-1:0] idx_nx;

  assign idx_nx = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
          src_d   = src_for(1'b1, 1'b0);
          dst_d   = dst_for(LAST_IDX == '0, 1'b0);
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_q + TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // A done arriving on the final timeout cycle still completes the layer.
        if (layer_done) begin
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_NEXT;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = S_ERROR;
        end
      end
      S_NEXT: begin
        state_d = S_LAUNCH;
        idx_d   = idx_nx;
        src_d   = src_for(1'b0, idx_nx[0]);
        dst_d   = dst_for(idx_nx == LAST_IDX, idx_nx[0]);
      end
      S_DONE: begin
        if (outputs_ack) state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      src_d   = SRC_EXT;
      dst_d   = DST_BUF_A;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      src_q   <= SRC_EXT;
      dst_q   <= DST_BUF_A;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign start_ready   = (state_q == S_IDLE);
  assign layer_start   = (state_q == S_LAUNCH);
  assign outputs_valid = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                         (state_q == S_NEXT)   || (state_q == S_DONE);
  assign layer_index   = idx_q;
  assign activation    = ACTIVATIONS[idx_q];
  assign src_sel       = src_q;
  assign dst_sel       = dst_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler: directed scenarios with a launch scoreboard for the
// three-layer, TIMEOUT=16 configuration of layer_scheduler.
module tb_layer_scheduler;

  typedef struct {
    int idx;
    int src;
    int dst;
    int act;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic       abort = 1'b0;
  logic       layer_start;
  logic [1:0] layer_index;
  logic       activation;
  logic [1:0] src_sel;
  logic [1:0] dst_sel;
  logic       layer_done = 1'b0;
  logic       outputs_valid;
  logic       outputs_ack = 1'b0;
  logic       busy;
  logic       error;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0;
  exp_t sb[$];
  exp_t e;

  layer_scheduler #(
    .DATA_WIDTH(32),
    .NUM_LAYERS(3),
    .TIMEOUT(16)
  ) dut (
    .clock(clk),
    .reset(reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort(abort),
    .layer_start(layer_start),
    .layer_index(layer_index),
    .activation(activation),
    .src_sel(src_sel),
    .dst_sel(dst_sel),
    .layer_done(layer_done),
    .outputs_valid(outputs_valid),
    .outputs_ack(outputs_ack),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_layer_start"}, 32'(layer_start), 32'd0);
    chk({tag, "_ov"}, 32'(outputs_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_index"}, 32'(layer_index), 32'd0);
    chk({tag, "_src"}, 32'(src_sel), 32'd0);
    chk({tag, "_dst"}, 32'(dst_sel), 32'd1);
    chk({tag, "_act"}, 32'(activation), 32'd0);
  endtask

  task automatic wait_launch(output exp_t x);
    int w = 0;
    while (layer_start !== 1'b1 && w < 30) begin
      tick();
      w++;
    end
    chk("launch_seen", 32'(layer_start), 32'd1);
    if (sb.size() > 0) x = sb.pop_front();
    else x = '{default: 0};
    chk("launch_idx", 32'(layer_index), 32'(x.idx));
    chk("launch_src", 32'(src_sel), 32'(x.src));
    chk("launch_dst", 32'(dst_sel), 32'(x.dst));
    chk("launch_act", 32'(activation), 32'(x.act));
    chk("launch_cyc", 32'(cyc), 32'(x.cyc));
  endtask

  task automatic run_layer(input int dly, input int hold);
    exp_t x;
    wait_launch(x);
    for (int k = 1; k <= dly; k++) begin
      tick();
      chk("wait_idx", 32'(layer_index), 32'(x.idx));
      chk("wait_src", 32'(src_sel), 32'(x.src));
      chk("wait_dst", 32'(dst_sel), 32'(x.dst));
      chk("wait_ls", 32'(layer_start), 32'd0);
      chk("wait_err", 32'(error), 32'd0);
    end
    layer_done = 1'b1;
    for (int h = 0; h < hold; h++) tick();
    layer_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("idle");

    // Normal three-layer run with done 5 cycles after each launch
    t0 = cyc;
    sb.push_back('{0, 0, 1, 0, t0 + 1});
    sb.push_back('{1, 1, 2, 0, t0 + 8});
    sb.push_back('{2, 2, 3, 1, t0 + 15});
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("launch_ready", 32'(start_ready), 32'd0);
    run_layer(5, 1);
    run_layer(5, 1);
    run_layer(5, 1);
    chk("ov_rise", 32'(outputs_valid), 32'd1);
    chk("ov_cyc", 32'(cyc), 32'(t0 + 21));

    // Backpressure on outputs_ack
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_ov", 32'(outputs_valid), 32'd1);
      chk("bp_ready", 32'(start_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    outputs_ack = 1'b1;
    tick();
    outputs_ack = 1'b0;
    chk("ack_ov", 32'(outputs_valid), 32'd0);
    chk("ack_ready", 32'(start_ready), 32'd1);
    chk("ack_busy", 32'(busy), 32'd0);

    // Spurious layer_done while idle
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    tick();
    chk("spur_idle_ready", 32'(start_ready), 32'd1);
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_ls", 32'(layer_start), 32'd0);

    // Timeout on layer 1; layer 0 done held into NEXT must be ignored
    t0 = cyc;
    sb.push_back('{0, 0, 1, 0, t0 + 1});
    sb.push_back('{1, 1, 2, 0, t0 + 8});
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    run_layer(5, 2);
    wait_launch(e);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("to_pre_err", 32'(error), 32'd0);
    end
    tick();
    chk("to_err", 32'(error), 32'd1);
    chk("to_err_cyc", 32'(cyc), 32'(t0 + 8 + 16));
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_ready", 32'(start_ready), 32'd0);
    chk("to_ov", 32'(outputs_valid), 32'd0);
    start_valid = 1'b1;
    layer_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_sticky", 32'(error), 32'd1);
      chk("to_no_ls", 32'(layer_start), 32'd0);
    end
    start_valid = 1'b0;
    layer_done = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_err", 32'(error), 32'd0);
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);

    // Done on the last timeout cycle wins over the timeout
    t0 = cyc;
    sb.push_back('{0, 0, 1, 0, t0 + 1});
    sb.push_back('{1, 1, 2, 0, t0 + 18});
    sb.push_back('{2, 2, 3, 1, t0 + 25});
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    run_layer(15, 1);
    chk("edge_err", 32'(error), 32'd0);
    chk("edge_busy", 32'(busy), 32'd1);
    run_layer(5, 1);
    run_layer(5, 1);
    chk("edge_ov", 32'(outputs_valid), 32'd1);
    chk("edge_ov_cyc", 32'(cyc), 32'(t0 + 31));
    outputs_ack = 1'b1;
    tick();
    outputs_ack = 1'b0;
    chk("edge_idle", 32'(start_ready), 32'd1);

    // Reset during WAIT of the last layer
    t0 = cyc;
    sb.push_back('{0, 0, 1, 0, t0 + 1});
    sb.push_back('{1, 1, 2, 0, t0 + 8});
    sb.push_back('{2, 2, 3, 1, t0 + 15});
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    run_layer(5, 1);
    run_layer(5, 1);
    wait_launch(e);
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    reset = 1'b0;
    tick();
    chk_reset_vals("postrst");
    tick();
    chk("postrst_ls", 32'(layer_start), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
